// File: rtl/score_keeper.sv
// score_keeper
//   Game score tracker for a grid snake game. A three-state game FSM
//   (IDLE / RUN / OVER) counts eat events while running and saturates the
//   score at H*V-1. A sequential double-dabble converter turns the score into
//   four BCD digits, one score bit per clock, MSB first.
//
//   Optional feature: define SCORE_KEEPER_HISCORE_EN to keep a best-score
//   register that loads on entry to OVER. Without it high_score is tied to 0.
//
// Parameters
//   H, V    grid width / height in cells (H*V <= 10000)
//   POINTS  score added per eat event (>= 1)
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset, overrides all other inputs
//   start           one-cycle pulse, begins a new game from IDLE or OVER
//   eat             one-cycle pulse, snake consumed food (counted only in RUN)
//   game_over       one-cycle pulse, fatal collision (acted on only in RUN)
//   score           current binary score (registered)
//   high_score      best score since reset (0 unless SCORE_KEEPER_HISCORE_EN)
//   bcd             {d3,d2,d1,d0} decimal digits of the last converted score
//   bcd_valid       bcd matches score
//   running         game FSM is in RUN
//   game_state_dbg  game FSM state: 0 IDLE, 1 RUN, 2 OVER
//   conv_state_dbg  converter state: 0 CIDLE, 1 CONV
module score_keeper #(
  parameter int H      = 32,
  parameter int V      = 32,
  parameter int POINTS = 1,
  localparam int W     = $clog2(H * V)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         eat,
  input  logic         game_over,
  output logic [W-1:0] score,
  output logic [W-1:0] high_score,
  output logic [15:0]  bcd,
  output logic         bcd_valid,
  output logic         running,
  output logic [1:0]   game_state_dbg,
  output logic         conv_state_dbg
);

  localparam int            CW        = $clog2(W + 1);
  localparam logic [CW-1:0] LAST      = CW'(W - 1);
  localparam logic [W:0]    MAX_SCORE = (W + 1)'(H * V - 1);
  localparam logic [W:0]    PTS       = (W + 1)'(POINTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_t;

  typedef enum logic {
    CIDLE = 1'b0,
    CONV  = 1'b1
  } conv_state_t;

  // ---------------------------------------------------------------------------
  // Game FSM and score register
  // ---------------------------------------------------------------------------
  game_state_t  state_q, state_d;
  logic [W-1:0] score_q, score_d;
  logic [W:0]   sum;
  logic [W-1:0] sat_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    // One extra bit so the add can never wrap before the saturation compare.
    sum     = {1'b0, score_q} + PTS;
    sat_sum = (sum > MAX_SCORE) ? MAX_SCORE[W-1:0] : sum[W-1:0];
    case (state_q)
      // start wins over a coincident eat: the new game begins at 0.
      IDLE, OVER: begin
        if (start) begin
          state_d = RUN;
          score_d = '0;
        end
      end
      // start is ignored here; eat and game_over together count the eat.
      RUN: begin
        if (eat)       score_d = sat_sum;
        if (game_over) state_d = OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  assign score          = score_q;
  assign running        = (state_q == RUN);
  assign game_state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // Best score
  // ---------------------------------------------------------------------------
`ifdef SCORE_KEEPER_HISCORE_EN
  logic [W-1:0] hi_q;

  // score_d is the post-eat value when eat and game_over coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
    end else if (state_q == RUN && game_over && score_d > hi_q) begin
      hi_q <= score_d;
    end
  end

  assign high_score = hi_q;
`else
  assign high_score = '0;
`endif

  // ---------------------------------------------------------------------------
  // Double-dabble BCD converter
  // ---------------------------------------------------------------------------
  // bcd_valid is a level, not a handshake: it is high exactly when bcd holds
  // the decimal form of the current score. It drops combinationally in the
  // same cycle score moves away from the snapshot, and rises on the cycle
  // after a conversion of the current score completes. There is no ready.
  conv_state_t  conv_q, conv_d;
  logic [W-1:0] snap_q;
  logic [W-1:0] shift_q;
  logic [14:0]  acc_q;
  logic [14:0]  adj;
  logic [15:0]  acc_next;
  logic [CW-1:0] cnt_q;
  logic [15:0]  bcd_q;
  logic         valid_q;

  // The accumulator is one bit short of 16: the thousands digit only ever
  // holds a prefix of a value below 10000, so before the final shift it is at
  // most 4 and never needs add-3, and its top bit only appears on that shift.
  always_comb begin
    conv_d = conv_q;
    adj    = acc_q;
    for (int i = 0; i < 3; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
    end
    acc_next = {adj, shift_q[W-1]};
    case (conv_q)
      CIDLE:   if (score_q != snap_q) conv_d = CONV;
      CONV:    if (cnt_q == LAST)     conv_d = CIDLE;
      default: conv_d = CIDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_q  <= CIDLE;
      snap_q  <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= 16'h0000;
      valid_q <= 1'b1;
    end else begin
      conv_q <= conv_d;
      case (conv_q)
        CIDLE: begin
          if (score_q != snap_q) begin
            snap_q  <= score_q;
            shift_q <= score_q;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
          end
        end
        CONV: begin
          // bcd_q is untouched until the last bit lands, so the previous
          // result stays visible for the whole conversion.
          acc_q   <= acc_next[14:0];
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            bcd_q   <= acc_next;
            valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd            = bcd_q;
  assign bcd_valid      = valid_q && (score_q == snap_q);
  assign conv_state_dbg = conv_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  localparam int H      = 32;
  localparam int V      = 32;
  localparam int POINTS = 1;
  localparam int W      = $clog2(H * V);
  localparam int MAXS   = H * V - 1;
  localparam int LAT    = 2 * W + 2;
  localparam int EW     = 2 * W + 2;
`ifdef SCORE_KEEPER_HISCORE_EN
  localparam bit HISCORE = 1'b1;
`else
  localparam bit HISCORE = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         eat;
  logic         game_over;
  logic [W-1:0] score;
  logic [W-1:0] high_score;
  logic [15:0]  bcd;
  logic         bcd_valid;
  logic         running;
  logic [1:0]   game_state_dbg;
  logic         conv_state_dbg;

  always #5 clk = ~clk;

  score_keeper #(.H(H), .V(V), .POINTS(POINTS)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .eat            (eat),
    .game_over      (game_over),
    .score          (score),
    .high_score     (high_score),
    .bcd            (bcd),
    .bcd_valid      (bcd_valid),
    .running        (running),
    .game_state_dbg (game_state_dbg),
    .conv_state_dbg (conv_state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [EW-1:0] exp_q[$];   // {rst_applied, running, high_score, score}

  // Reference model: a game is either in progress or not; IDLE and OVER react
  // to inputs identically, so one flag is enough.
  bit m_run   = 1'b0;
  int m_score = 0;
  int m_hi    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [3:0] d[4];
    for (int i = 0; i < 4; i++) begin
      d[i] = 4'(v % 10);
      v    = v / 10;
    end
    return {d[3], d[2], d[1], d[0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one call = one clock of stimulus plus the expected result
  // ---------------------------------------------------------------------------
  task automatic step(input bit s, input bit e, input bit g, input bit r);
    @(negedge clk);
    start     = s;
    eat       = e;
    game_over = g;
    rst       = r;
    if (r) begin
      m_run   = 1'b0;
      m_score = 0;
      m_hi    = 0;
    end else if (m_run) begin
      if (e) m_score = (m_score + POINTS > MAXS) ? MAXS : m_score + POINTS;
      if (g) begin
        m_run = 1'b0;
        if (HISCORE && m_score > m_hi) m_hi = m_score;
      end
    end else if (s) begin
      m_run   = 1'b1;
      m_score = 0;
    end
    exp_q.push_back({r, m_run, W'(m_hi), W'(m_score)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops one expectation per clock and checks the registered outputs
  // ---------------------------------------------------------------------------
  initial begin
    logic [EW-1:0] e;
    bit rf;
    bit er;
    int es;
    int eh;
    int prev  = 0;
    int since = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) continue;
      e  = exp_q.pop_front();
      rf = e[EW-1];
      er = e[EW-2];
      eh = int'(e[2*W-1:W]);
      es = int'(e[W-1:0]);
      check("score", 32'(score), es);
      check("running", 32'(running), 32'(er));
      check("high_score", 32'(high_score), eh);
      if (rf) begin
        check("rst_bcd", 32'(bcd), 0);
        check("rst_bcd_valid", 32'(bcd_valid), 1);
        prev  = 0;
        since = 0;
      end else begin
        if (es != prev) begin
          check("bcd_valid_low_on_change", 32'(bcd_valid), 0);
          prev  = es;
          since = 0;
        end else begin
          since++;
        end
        if (since == LAT) check("bcd_latency", 32'(bcd_valid), 1);
      end
      if (bcd_valid === 1'b1) check("bcd_value", 32'(bcd), 32'(to_bcd(es)));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit seen9;
    bit got10;
    int eat_div;
    rst = 1'b1; start = 1'b0; eat = 1'b0; game_over = 1'b0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    idle(2);

    // Three eats spaced two cycles apart.
    step(1, 0, 0, 0);
    repeat (3) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end
    idle(22);
    check("three_eats_score", 32'(score), 3);
    check("three_eats_bcd", 32'(bcd), 32'h0003);
    check("three_eats_valid", 32'(bcd_valid), 1);

    // Score 8 settled, eat to 9, then eat to 10 mid-conversion.
    repeat (5) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
    end
    idle(LAT + 2);
    step(0, 1, 0, 0);
    idle(4);
    step(0, 1, 0, 0);
    seen9 = 1'b0;
    got10 = 1'b0;
    for (int i = 0; i < 3 * W + 6; i++) begin
      step(0, 0, 0, 0);
      if (bcd == 16'h0009) seen9 = 1'b1;
      if (bcd == 16'h0010 && bcd_valid) begin
        got10 = 1'b1;
        break;
      end
    end
    check("restart_shows_9_first", 32'(seen9), 1);
    check("restart_then_10", 32'(got10), 1);

    // Up to 41, then eat and game_over together.
    repeat (31) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    idle(1);
    check("eat_over_score", 32'(score), 42);
    check("eat_over_running", 32'(running), 0);
    check("eat_over_high", 32'(high_score), HISCORE ? 42 : 0);
    check("eat_over_state", 32'(game_state_dbg), 2);

    // Inputs ignored in OVER, start wins over eat, start ignored in RUN.
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    idle(1);
    check("over_eat_ignored", 32'(score), 42);
    step(1, 1, 0, 0);
    idle(1);
    check("start_eat_score", 32'(score), 0);
    check("start_eat_running", 32'(running), 1);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    idle(1);
    check("start_in_run_ignored", 32'(score), 2);

    // Saturation at H*V-1.
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    repeat (MAXS + 5) step(0, 1, 0, 0);
    idle(LAT + 2);
    check("sat_score", 32'(score), MAXS);
    check("sat_bcd", 32'(bcd), 32'(to_bcd(MAXS)));
    step(0, 1, 1, 0);
    idle(1);
    check("sat_high", 32'(high_score), HISCORE ? MAXS : 0);

    // Reset in the middle of converting 500.
    step(1, 0, 0, 0);
    repeat (499) step(0, 1, 0, 0);
    idle(LAT + 2);
    step(0, 1, 0, 0);
    idle(3);
    check("conv_busy_before_rst", 32'(conv_state_dbg), 1);
    step(0, 0, 0, 1);
    idle(1);
    check("rst_mid_score", 32'(score), 0);
    check("rst_mid_bcd", 32'(bcd), 0);
    check("rst_mid_valid", 32'(bcd_valid), 1);
    check("rst_mid_state", 32'(game_state_dbg), 0);
    check("rst_mid_conv", 32'(conv_state_dbg), 0);
    check("rst_mid_high", 32'(high_score), 0);

    // Randomised play: busy eating first, then sparse eats so conversions finish.
    for (int i = 0; i < 4000; i++) begin
      eat_div = (i < 2000) ? 2 : 25;
      step($urandom_range(0, 29) == 0,
           $urandom_range(0, eat_div) == 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 399) == 0);
    end

    idle(LAT + 4);
    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter: H, default 32, grid width in cells.
REQ-002 Parameter: V, default 32, grid height in cells.
REQ-003 Parameter: POINTS, default 1, score added per eat event; POINTS SHALL be at least 1.
REQ-004 Derived width: W = ceil(log2(H*V)); H*V SHALL be at most 10000, so four decimal digits always suffice.
REQ-005 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: start  input  1  one-cycle pulse that begins a new game.
REQ-008 Port: eat  input  1  one-cycle pulse meaning the snake consumed food.
REQ-009 Port: game_over  input  1  one-cycle pulse meaning a fatal collision occurred.
REQ-010 Port: score  output  W  current binary score, wired straight to score_print.score.
REQ-011 Port: high_score  output  W  best score since reset.
REQ-012 Port: bcd  output  16  {d3,d2,d1,d0} decimal digits of score, d3 most significant.
REQ-013 Port: bcd_valid  output  1  high when bcd matches score.
REQ-014 Port: running  output  1  high while the game FSM is in RUN.

Function
REQ-015 Game FSM SHALL have three states: IDLE, RUN and OVER.
REQ-016 IDLE: on start, go to RUN with score cleared to 0.
REQ-017 RUN: eat adds POINTS to score; game_over goes to OVER.
REQ-018 OVER: on start, clear score to 0 and go to RUN.
REQ-019 eat SHALL be ignored in IDLE and OVER; game_over SHALL be ignored in IDLE and OVER.
REQ-020 Score arithmetic SHALL be computed in W+1 bits and saturate at H*V-1, never wrapping.
REQ-021 If eat and game_over coincide in RUN, the eat SHALL be counted and the FSM SHALL enter OVER in the same cycle.
REQ-022 If start coincides with eat in OVER or IDLE, score SHALL become 0; the eat is discarded.
REQ-023 If start arrives in RUN, it SHALL be ignored.
REQ-024 score SHALL update one cycle after the qualifying input edge (registered output).
REQ-025 BCD converter SHALL be a sequential double-dabble with states CIDLE and CONV.
REQ-026 The converter SHALL process one score bit per clock, MSB first, applying add-3 to each digit that is 5 or more before each shift.
REQ-027 Conversion start: in CIDLE, when score differs from the last converted snapshot, capture score into the snapshot, clear bcd_valid, and enter CONV.
REQ-028 CONV SHALL last exactly W cycles, then write bcd, set bcd_valid and return to CIDLE.
REQ-029 bcd SHALL hold its previous value throughout CONV.
REQ-030 A score change during CONV SHALL NOT abort the conversion; the REQ-027 compare then restarts conversion on the cycle after return to CIDLE.
REQ-031 bcd_valid SHALL be low in any cycle where score differs from the snapshot.
REQ-032 Worst-case latency from a score change to bcd_valid SHALL be 2W+2 cycles.

Reset
REQ-033 On rst high at a clock edge: FSM goes to IDLE, score=0, high_score=0, snapshot=0, bcd=16'h0000, bcd_valid=1, running=0, converter to CIDLE.
REQ-034 rst SHALL override start, eat and game_over in the same cycle.
REQ-035 rst asserted mid-conversion SHALL discard the conversion.

Configuration
REQ-036 Macro SCORE_KEEPER_HISCORE_EN, when defined: on entry to OVER, high_score SHALL load score if score is greater than high_score, using the post-eat value when REQ-021 applies.
REQ-037 Macro SCORE_KEEPER_HISCORE_EN, when undefined: high_score SHALL be constant 0 and no high-score register SHALL be synthesized.

Verification
REQ-038 Reset, start, then 3 eat pulses spaced 2 cycles apart -> score=3; after at most 22 cycles, bcd=16'h0003 and bcd_valid=1.
REQ-039 H=V=32, preload via 1023 eats, then one more eat -> score stays 1023 and bcd=16'h1023.
REQ-040 eat and game_over in the same cycle at score 41 -> score=42, running=0; with the macro defined, high_score=42.
REQ-041 eat pulse on the 5th cycle of CONV (score 9 to 10) -> bcd first shows 16'h0009, then restarts and shows 16'h0010; bcd_valid is low in between.
REQ-042 rst asserted during CONV with score 500 -> next cycle score=0, bcd=16'h0000, bcd_valid=1, FSM in IDLE.
REQ-043 OVER at score 7, then start -> score=0, running=1; eat in OVER before start -> no change.
